div_ctrl: RTL and testbench
===========================

// Module: div_ctrl
// PURPOSE
// - Multi-cycle controller and datapath for MIPS DIV/DIVU in the EX stage. Feeds the HI/LO write path.
// - Quotient is written to LO and remainder to HI.
// - Runs a 32-iteration radix-2 restoring divide.
// - Stalls the pipeline while busy and cancels cleanly on exception flush.
// PARAMETERS
// - WIDTH    32   operand width; the iteration count equals WIDTH
// - CNT_W    6    iteration counter width; must hold the value WIDTH
// PORTS
// - clk         in   1        clock, rising edge
// - rst         in   1        asynchronous, active-high reset
// - start_i     in   1        DIV/DIVU present in EX (decoded hilo-op, funct DIV/DIVU)
// - signed_i    in   1        1 = DIV (signed), 0 = DIVU
// - opa_i       in   WIDTH    dividend (rs value after forwarding)
// - opb_i       in   WIDTH    divisor (rt value after forwarding)
// - annul_i     in   1        flush from exception or ERET; aborts the divide
// - hold_i      in   1        pipeline held by another stall source
// - result_o    out  2*WIDTH  {HI = remainder, LO = quotient}
// - ready_o     out  1        result_o valid this cycle
// - stall_o     out  1        request EX stall: start_i & ~ready_o
// BEHAVIOUR
// - Reset (async, immediate):
//   - state = IDLE; counter, dividend/divisor regs and result_o = 0.
//   - ready_o = 0, stall_o = 0.
// - States: IDLE, DIVZERO, ON, END (2-bit, encodings in defines.vh).
// - IDLE:
//   - On start_i & ~annul_i, latch the operands.
//   - If opb_i == 0, go to DIVZERO.
//   - Otherwise go to ON. Latch |opa| and |opb| when signed_i is set, raw values when not.
//   - Latch neg_q = signed_i & (opa[31]^opb[31]) and neg_r = signed_i & opa[31]. Clear the counter.
// - ON:
//   - Each cycle performs one restoring step on the {rem,quo} 65-bit shift register: shift left 1.
//   - Trial = rem - divisor. If there is no borrow, rem = trial and quo[0] = 1.
//   - The counter increments. After the step where counter == WIDTH-1, go to END.
// - DIVZERO: result = {32'h0, 32'h0}; next state END. No exception is raised (MIPS leaves this undefined).
// - END:
//   - Apply signs: quo = neg_q ? -quo : quo; rem = neg_r ? -rem : rem. Write result_o.
//   - ready_o = 1 (registered, asserted for the whole END state).
//   - Stay in END while hold_i = 1. Otherwise return to IDLE next cycle.
// - Latency: start sampled at cycle T.
//   - Normal divide: ON for T+1..T+32, ready_o at T+33.
//   - Divide by zero: ready_o at T+2.
// - result_o holds its last value until the next END. ready_o = 0 outside END.
// - stall_o is combinational: high while start_i and not yet ready. It drops in the END cycle so EX advances.
// - annul_i in any state: state goes to IDLE next cycle, ready_o = 0, and result_o is not updated.
//   - annul_i wins over start_i in IDLE.
// - annul_i together with END: the result is discarded. The HI/LO write is gated downstream by the flush.
// - Signed overflow 0x80000000 / 0xFFFFFFFF: quo = 0x80000000, rem = 0 (two's-complement wrap, no trap).
// - Operand changes on opa_i/opb_i after IDLE are ignored; the latched copies are used.
// - A start_i still high on the cycle after END returns to IDLE is treated as a new divide.
//   - This is correct because the pipeline has advanced.
// STRUCTURE
// - defines.vh:
//   - DIV_IDLE/DIV_DIVZERO/DIV_ON/DIV_END state codes.
//   - DIV_ITER = 32. The existing EXE_DIV/EXE_DIVU funct codes are reused by the decoder that drives start_i.
// - Sub-module div_step: one combinational restoring step, taking {rem,quo} and divisor and giving the next {rem,quo}.
// - div_ctrl holds the FSM, counter, sign fix-up and the registers.
// TESTING
// - DIVU 100 / 7, start at T:
//   - stall_o = 1 for T..T+32.
//   - At T+33: ready_o = 1, result_o = {32'd2, 32'd14}, stall_o = 0.
// - DIV -7 / 2: result_o = {32'hFFFFFFFF, 32'hFFFFFFFD} (rem -1, quo -3) at T+33.
// - DIV 5 / 0: ready_o at T+2, result_o = 64'h0, no ready pulse at T+33.
// - DIV 100 / 7 with annul_i = 1 at T+10:
//   - state = IDLE at T+11, stall_o follows start_i (0).
//   - ready_o stays 0 and result_o is unchanged from its prior value.
// - DIV 0x80000000 / 0xFFFFFFFF: result_o = {32'h0, 32'h80000000} at T+33.
// - hold_i = 1 for 3 cycles from T+33: ready_o stays 1 for T+33..T+36 and result is stable.
//   - After hold drops, IDLE. A new start then restarts with latency 33.
// - Async reset asserted mid-divide (T+5): all outputs = 0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/div_ctrl_pkg.sv
// Shared constants and state encoding for the multi-cycle DIV/DIVU unit.
// Quotient goes to LO and remainder to HI.
package div_ctrl_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = 6;
    localparam int DIV_ITER  = DIV_WIDTH;

    typedef enum logic [1:0] {
        DIV_IDLE    = 2'd0,
        DIV_DIVZERO = 2'd1,
        DIV_ON      = 2'd2,
        DIV_END     = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring divide step on the {rem,quo} pair.
// The shifted remainder is one bit wider than the divisor.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0]   shift_rem;
    logic [WIDTH-1:0] trial;
    logic             no_borrow;

    always_comb begin
        shift_rem = {rem_i, quo_i[WIDTH-1]};
        no_borrow = (shift_rem >= {1'b0, divisor_i});
        // A successful subtraction always lands below the divisor, so the low WIDTH bits suffice.
        trial     = shift_rem[WIDTH-1:0] - divisor_i;
        rem_o     = no_borrow ? trial : shift_rem[WIDTH-1:0];
        quo_o     = {quo_i[WIDTH-2:0], no_borrow};
    end

endmodule

// File: rtl/div_ctrl.sv
// EX-stage DIV/DIVU controller: IDLE -> ON (WIDTH restoring steps) -> END, with a
// short DIVZERO path. result_o = {HI = remainder, LO = quotient}, valid while ready_o.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   opa_i,
    input  logic [WIDTH-1:0]   opb_i,
    input  logic               annul_i,
    input  logic               hold_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               stall_o,
    output div_state_e         state_o
);

    div_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   divisor_q, divisor_d;
    logic               quo_neg_q, quo_neg_d;
    logic               rem_neg_q, rem_neg_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0]   step_rem, step_quo;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (divisor_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        divisor_d = divisor_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        result_d  = result_q;

        // A flush aborts from any state and never touches the result register.
        if (annul_i) begin
            state_d = DIV_IDLE;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (start_i) begin
                        state_d   = (opb_i == '0) ? DIV_DIVZERO : DIV_ON;
                        rem_d     = '0;
                        quo_d     = (signed_i && opa_i[WIDTH-1]) ? -opa_i : opa_i;
                        divisor_d = (signed_i && opb_i[WIDTH-1]) ? -opb_i : opb_i;
                        quo_neg_d = signed_i && (opa_i[WIDTH-1] ^ opb_i[WIDTH-1]);
                        rem_neg_d = signed_i && opa_i[WIDTH-1];
                        cnt_d     = '0;
                    end
                end
                DIV_ON: begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d  = DIV_END;
                        result_d = {rem_neg_q ? -step_rem : step_rem,
                                    quo_neg_q ? -step_quo : step_quo};
                    end
                end
                DIV_DIVZERO: begin
                    state_d  = DIV_END;
                    result_d = '0;
                end
                DIV_END: begin
                    if (!hold_i) begin
                        state_d = DIV_IDLE;
                    end
                end
                default: state_d = DIV_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= DIV_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            divisor_q <= divisor_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
            result_q  <= result_d;
        end
    end

    // stall_o is masked by rst so every output is quiet while reset is held.
    assign ready_o  = (state_q == DIV_END);
    assign stall_o  = start_i & ~ready_o & ~rst;
    assign result_o = result_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: drivers push expected {HI,LO} and ready cycle into
// queues; a negedge monitor pops and compares on each new ready_o.
module tb_div_ctrl;
    import div_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic        signed_i = 1'b0;
    logic [31:0] opa_i = '0;
    logic [31:0] opb_i = '0;
    logic        annul_i = 1'b0;
    logic        hold_i = 1'b0;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stall_o;
    div_state_e  state_o;

    logic [63:0] exp_q[$];
    int          exp_cyc_q[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    logic        ready_prev = 1'b0;

    div_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .signed_i (signed_i),
        .opa_i    (opa_i),
        .opb_i    (opb_i),
        .annul_i  (annul_i),
        .hold_i   (hold_i),
        .result_o (result_o),
        .ready_o  (ready_o),
        .stall_o  (stall_o),
        .state_o  (state_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: act=%h exp=%h (cycle %0d)", name, act, exp, cyc);
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!rst && ready_o && !ready_prev) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ready", 64'(exp_q.size()), 64'd1);
            end else begin
                check("result", result_o, exp_q.pop_front());
                check("ready_cycle", 64'(cyc), 64'(exp_cyc_q.pop_front()));
            end
        end
        ready_prev <= ready_o;
    end

    // ---------------- driver tasks ----------------
    task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int lat, input int hold_n,
                          output int t0);
        logic stall_ok;
        logic got;
        @(negedge clk);
        start_i  = 1'b1;
        signed_i = sgn;
        opa_i    = a;
        opb_i    = b;
        t0       = cyc;
        exp_q.push_back(exp);
        exp_cyc_q.push_back(t0 + lat);
        stall_ok = 1'b1;
        got      = 1'b0;
        for (int i = 0; i < lat + 4 && !got; i++) begin
            @(negedge clk);
            if (ready_o) got = 1'b1;
            else if (!stall_o) stall_ok = 1'b0;
            // Latched copies must be used, so scramble the live operands.
            opa_i = $urandom;
            opb_i = $urandom;
        end
        check("stall_while_busy", 64'(stall_ok), 64'd1);
        check("ready_seen", 64'(got), 64'd1);
        if (got) check("stall_in_end", 64'(stall_o), 64'd0);
        start_i = 1'b0;
        hold_i  = (hold_n > 0);
        for (int i = 1; i <= hold_n; i++) begin
            @(negedge clk);
            check("hold_ready", 64'(ready_o), 64'd1);
            check("hold_result", result_o, exp);
            hold_i = (i < hold_n);
        end
        @(negedge clk);
        check("back_idle", 64'(state_o), 64'(DIV_IDLE));
        check("ready_low_after", 64'(ready_o), 64'd0);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int t0;
        logic [63:0] prior;

        #12;
        check("reset_result", result_o, 64'd0);
        check("reset_ready", 64'(ready_o), 64'd0);
        check("reset_stall", 64'(stall_o), 64'd0);
        check("reset_state", 64'(state_o), 64'(DIV_IDLE));
        @(negedge clk);
        rst = 1'b0;

        do_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 0, t0);
        do_div(1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 0, t0);

        // Flush at T+10 with start dropped by the flushed pipeline.
        prior = result_o;
        @(negedge clk);
        start_i = 1'b1; signed_i = 1'b1; opa_i = 32'd100; opb_i = 32'd7;
        t0 = cyc;
        while (cyc < t0 + 10) @(negedge clk);
        annul_i = 1'b1;
        start_i = 1'b0;
        @(negedge clk);
        check("annul_state", 64'(state_o), 64'(DIV_IDLE));
        check("annul_stall", 64'(stall_o), 64'd0);
        check("annul_ready", 64'(ready_o), 64'd0);
        annul_i = 1'b0;
        repeat (30) @(negedge clk);
        check("annul_result_kept", result_o, prior);

        // Divide by zero: ready at T+2 and no late ready at T+33.
        do_div(1'b1, 32'd5, 32'd0, 64'd0, 2, 0, t0);
        while (cyc <= t0 + 34) begin
            @(negedge clk);
            if (ready_o) check("divzero_no_late_ready", 64'(ready_o), 64'd0);
        end
        check("divzero_result", result_o, 64'd0);

        do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 33, 3, t0);
        do_div(1'b1, 32'd100, 32'hFFFF_FFF9, {32'd2, 32'hFFFF_FFF2}, 33, 0, t0);
        do_div(1'b0, 32'hFFFF_FFF9, 32'd2, {32'd1, 32'h7FFF_FFFC}, 33, 0, t0);
        do_div(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'd0, 32'd1}, 33, 0, t0);
        do_div(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, {32'hFFFF_FFFE, 32'd14}, 33, 0, t0);
        do_div(1'b0, 32'h1234_5678, 32'h0000_0100, {32'h78, 32'h0012_3456}, 33, 0, t0);

        // Flush beats a simultaneous start in IDLE.
        @(negedge clk);
        start_i = 1'b1; annul_i = 1'b1; opa_i = 32'd9; opb_i = 32'd3;
        @(negedge clk);
        check("annul_beats_start", 64'(state_o), 64'(DIV_IDLE));
        start_i = 1'b0; annul_i = 1'b0;
        repeat (36) @(negedge clk);

        // Asynchronous reset mid-divide, asserted away from any clock edge.
        @(negedge clk);
        start_i = 1'b1; signed_i = 1'b0; opa_i = 32'd100; opb_i = 32'd7;
        t0 = cyc;
        while (cyc < t0 + 5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_result", result_o, 64'd0);
        check("async_rst_ready", 64'(ready_o), 64'd0);
        check("async_rst_stall", 64'(stall_o), 64'd0);
        check("async_rst_state", 64'(state_o), 64'(DIV_IDLE));
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);

        do_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 0, t0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
